// File: rtl/hazard_pkg.sv
// Shared pipeline constants for the hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard detection, ID-stage forwarding select,
// flush arbitration and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_is_branch,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_read,
    input  logic [4:0]             ex_rd,
    input  logic                   mem_reg_write,
    input  logic                   mem_mem_read,
    input  logic [4:0]             mem_rd,
    input  logic [1:0]             pc_src,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   control_sel,
    output logic                   forward_c,
    output logic                   forward_d,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    hz_state_e  state, state_nxt;
    logic [1:0] rem, rem_nxt;
    logic [1:0] n_stall;
    logic       stall;
    logic       dep_ex, dep_mem;

    assign dep_ex  = ex_reg_write && (ex_rd != REG_ZERO) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign dep_mem = mem_reg_write && (mem_rd != REG_ZERO) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

    // Longest requirement wins when several producers conflict at once.
    always_comb begin
        n_stall = 2'd0;
        if (dep_ex && ex_mem_read)
            n_stall = id_is_branch ? 2'd2 : 2'd1;
        else if ((dep_ex && id_is_branch) || (dep_mem && mem_mem_read && id_is_branch))
            n_stall = 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 2'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        stall     = 1'b0;
        case (state)
            RUN: begin
                stall = (n_stall != 2'd0);
                if (n_stall == 2'd2) begin
                    rem_nxt   = 2'd1;
                    state_nxt = STALL;
                end
            end
            STALL: begin
                // Hazards are frozen here; only the countdown matters.
                stall = 1'b1;
                if (rem <= 2'd1) begin
                    rem_nxt   = 2'd0;
                    state_nxt = RUN;
                end else begin
                    rem_nxt   = rem - 2'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                rem_nxt   = 2'd0;
            end
        endcase
    end

    assign pc_write    = rst_n & ~stall;
    assign if_id_write = rst_n & ~stall;
    assign control_sel = rst_n & ~stall;
    assign if_id_flush = rst_n & ~stall & (pc_src != 2'b00);

    assign forward_c = rst_n & id_is_branch & mem_reg_write & ~mem_mem_read &
                       (mem_rd != REG_ZERO) & (mem_rd == id_rs);
    assign forward_d = rst_n & id_is_branch & mem_reg_write & ~mem_mem_read &
                       id_uses_rt & (mem_rd != REG_ZERO) & (mem_rd == id_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (!pc_write && (stall_cycles != {STALL_CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level model of the stall/forward/flush rules.
module tb_hazard_ctrl;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic          id_uses_rt = 1'b0, id_is_branch = 1'b0;
    logic          ex_reg_write = 1'b0, ex_mem_read = 1'b0;
    logic          mem_reg_write = 1'b0, mem_mem_read = 1'b0;
    logic [1:0]    pc_src = '0;
    logic          pc_write, if_id_write, if_id_flush, control_sel, forward_c, forward_d;
    logic [CW-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: forced stall cycles still owed, and the expected counter
    int m_left = 0;
    int m_cnt  = 0;

    hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
        .pc_src(pc_src),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .control_sel(control_sel), .forward_c(forward_c), .forward_d(forward_d),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] r);
        return (r != 5'd0) && ((r == id_rs) || (id_uses_rt && (r == id_rt)));
    endfunction

    function automatic int need_stall();
        int n;
        bit de, dm;
        de = ex_reg_write && reads(ex_rd);
        dm = mem_reg_write && reads(mem_rd);
        n = 0;
        if (de && ex_mem_read && id_is_branch)  n = (n > 2) ? n : 2;
        if (de && ex_mem_read && !id_is_branch) n = (n > 1) ? n : 1;
        if (de && !ex_mem_read && id_is_branch) n = (n > 1) ? n : 1;
        if (dm && mem_mem_read && id_is_branch) n = (n > 1) ? n : 1;
        return n;
    endfunction

    // Per-cycle compare against the model, at the falling edge.
    always @(negedge clk) begin
        int n;
        bit stalled, fc, fd;
        if (!rst_n) begin
            m_left = 0;
            m_cnt  = 0;
            chk("rst pc_write", pc_write, 0);
            chk("rst if_id_write", if_id_write, 0);
            chk("rst control_sel", control_sel, 0);
            chk("rst flush", if_id_flush, 0);
            chk("rst fwd_c", forward_c, 0);
            chk("rst fwd_d", forward_d, 0);
            chk("rst cnt", stall_cycles, 0);
        end else begin
            n = need_stall();
            stalled = (m_left > 0) || (n > 0);
            fc = id_is_branch && mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == id_rs;
            fd = id_is_branch && mem_reg_write && !mem_mem_read && id_uses_rt &&
                 mem_rd != 0 && mem_rd == id_rt;
            chk("pc_write", pc_write, !stalled);
            chk("if_id_write", if_id_write, !stalled);
            chk("control_sel", control_sel, !stalled);
            chk("if_id_flush", if_id_flush, (pc_src != 0) && !stalled);
            chk("forward_c", forward_c, fc);
            chk("forward_d", forward_d, fd);
            chk("stall_cycles", stall_cycles, m_cnt);
            if (m_left > 0) m_left--;
            else if (n > 0) m_left = n - 1;
            if (stalled && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; id_is_branch = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
        mem_reg_write = 0; mem_mem_read = 0; mem_rd = 0; pc_src = 0;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        clr();
        step();
        settle();
        chk("lit reset pc_write", pc_write, 0);
        chk("lit reset cnt", stall_cycles, 0);
        step();
        rst_n = 1'b1;

        // register 0 never creates a dependency
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_is_branch = 1;
        settle();
        chk("lit r0 pc_write", pc_write, 1);
        chk("lit r0 fwd_c", forward_c, 0);
        step();

        // ALU result in MEM feeding a branch: forward, no stall
        clr();
        mem_reg_write = 1; mem_rd = 9; id_rs = 9; id_is_branch = 1;
        settle();
        chk("lit fwd_c", forward_c, 1);
        chk("lit fwd pc_write", pc_write, 1);
        step();

        // redirect without hazard flushes for exactly that cycle
        clr();
        pc_src = 2'b01;
        settle();
        chk("lit flush", if_id_flush, 1);
        step();
        pc_src = 2'b00;
        settle();
        chk("lit flush off", if_id_flush, 0);
        step();

        // load feeding a branch: two stall cycles, flush suppressed
        clr();
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_is_branch = 1; pc_src = 2'b01;
        settle();
        chk("lit lb c0 pc_write", pc_write, 0);
        chk("lit lb c0 flush", if_id_flush, 0);
        step();
        clr();
        pc_src = 2'b01;
        settle();
        chk("lit lb c1 pc_write", pc_write, 0);
        chk("lit lb c1 flush", if_id_flush, 0);
        step();
        pc_src = 2'b00;
        settle();
        chk("lit lb c2 pc_write", pc_write, 1);
        chk("lit lb cnt", stall_cycles, 2);
        step();

        // load-use on rt, no branch: single bubble, no extended stall
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1;
        settle();
        chk("lit lu control_sel", control_sel, 0);
        step();
        clr();
        settle();
        chk("lit lu after pc_write", pc_write, 1);
        chk("lit lu cnt", stall_cycles, 3);
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 0;
        settle();
        chk("lit rt unused pc_write", pc_write, 1);
        step();

        // reset in the STALL cycle aborts the stall immediately
        clr();
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 3; id_rs = 3; id_is_branch = 1;
        step();
        rst_n = 1'b0;
        #1;
        chk("lit async pc_write", pc_write, 0);
        chk("lit async cnt", stall_cycles, 0);
        step();
        clr();
        rst_n = 1'b1;
        settle();
        chk("lit post-rst pc_write", pc_write, 1);
        step();
        settle();
        chk("lit post-rst cnt", stall_cycles, 0);

        // randomized traffic with narrow register fields to provoke matches
        for (int i = 0; i < 3000; i++) begin
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_uses_rt    = 1'($urandom);
            id_is_branch  = 1'($urandom);
            ex_reg_write  = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            ex_rd         = 5'($urandom_range(0, 3));
            mem_reg_write = 1'($urandom);
            mem_mem_read  = 1'($urandom);
            mem_rd        = 5'($urandom_range(0, 3));
            pc_src        = 2'($urandom);
            rst_n         = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            step();
        end

        // saturation: continuous load-branch hazard drives the counter to all-ones
        clr();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_is_branch = 1;
        for (int i = 0; i < 40; i++) step();
        settle();
        chk("lit sat cnt", stall_cycles, CNT_MAX);
        for (int i = 0; i < 5; i++) step();
        settle();
        chk("lit sat hold", stall_cycles, CNT_MAX);
        clr();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
